// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA pixel pipeline.
//   - 640x480@60 timing constants (active area, sync positions, totals).
//   - rgb12_t : {R[3:0],G[3:0],B[3:0]} pixel word for the Basys3 DAC.
//   - coord_t : 10-bit pixel/line coordinate.
//   - axis_t  : one motion axis (position plus direction flag).
//   - bounce_step : one motion update of a single axis, with edge reflection.
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 752;
    localparam int H_TOTAL      = 800;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 492;
    localparam int V_TOTAL      = 525;

    typedef logic [11:0] rgb12_t;
    typedef logic [9:0]  coord_t;

    typedef struct packed {
        coord_t pos;     // leading (left/top) edge of the box
        logic   dirNeg;  // 1 = moving towards 0, 0 = moving away from 0
    } axis_t;

    // One motion update of a single axis. All arithmetic is 11-bit so
    // pos+step never wraps. Hitting either wall clamps the position onto
    // the wall and reverses direction in the same update.
    function automatic axis_t bounce_step(input axis_t      cur,
                                          input logic [10:0] limit,
                                          input logic [10:0] step);
        axis_t      nxt;
        logic [10:0] pos11;
        logic [10:0] sum11;
        logic [10:0] dif11;
        nxt   = cur;
        pos11 = {1'b0, cur.pos};
        sum11 = pos11 + step;
        dif11 = pos11 - step;
        if (!cur.dirNeg) begin
            if (sum11 >= limit) begin
                nxt.pos    = limit[9:0];
                nxt.dirNeg = 1'b1;
            end else begin
                nxt.pos = sum11[9:0];
            end
        end else begin
            if (pos11 <= step) begin
                nxt.pos    = '0;
                nxt.dirNeg = 1'b0;
            end else begin
                nxt.pos = dif11[9:0];
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vga_box_motion.sv
// ---------------------------------------------------------------------------
// vga_box_motion
// Position controller for the bouncing box. Counts frame ticks and, once
// every FRAME_DIV ticks, advances both axes by STEP pixels with reflection
// at the active-area edges. Updates happen only on frame_tick, which sits
// inside vertical blanking, so a rendered frame never sees a moving box.
//
// Ports:
//   vga_clk   in   pixel clock
//   rst       in   asynchronous active-high reset
//   frameTick in   1-cycle pulse at the start of vertical sync
//   move_en   in   1 = apply the update, 0 = hold position/direction
//   boxX      out  box left edge
//   boxY      out  box top edge
//
// Internal state worth probing: xAxis/yAxis (position + direction) and
// divCnt (frame divider).
// ---------------------------------------------------------------------------
module vga_box_motion
    import vga_pkg::*;
#(
    parameter int BOX_W     = 32,
    parameter int BOX_H     = 32,
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 1,
    parameter int INIT_X    = 0,
    parameter int INIT_Y    = 0
) (
    input  logic   vga_clk,
    input  logic   rst,
    input  logic   frameTick,
    input  logic   move_en,
    output coord_t boxX,
    output coord_t boxY
);

    // Largest legal left/top edge: the box must stay fully on screen.
    localparam logic [10:0] X_LIMIT  = 11'(H_ACTIVE - BOX_W);
    localparam logic [10:0] Y_LIMIT  = 11'(V_ACTIVE - BOX_H);
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);

    axis_t      xAxis;
    axis_t      yAxis;
    axis_t      xAxisNext;
    axis_t      yAxisNext;
    logic [7:0] divCnt;
    logic       updateDue;

    // The divider keeps running while move_en is low; only the position
    // update itself is suppressed.
    always_comb begin
        updateDue = frameTick && (divCnt == DIV_LAST);
        xAxisNext = xAxis;
        yAxisNext = yAxis;
        if (updateDue && move_en) begin
            xAxisNext = bounce_step(xAxis, X_LIMIT, STEP_W);
            yAxisNext = bounce_step(yAxis, Y_LIMIT, STEP_W);
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            divCnt <= '0;
        end else if (frameTick) begin
            if (divCnt == DIV_LAST) begin
                divCnt <= '0;
            end else begin
                divCnt <= divCnt + 8'd1;
            end
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            xAxis.pos    <= 10'(INIT_X);
            xAxis.dirNeg <= 1'b0;
            yAxis.pos    <= 10'(INIT_Y);
            yAxis.dirNeg <= 1'b0;
        end else begin
            xAxis <= xAxisNext;
            yAxis <= yAxisNext;
        end
    end

    assign boxX = xAxis.pos;
    assign boxY = yAxis.pos;

endmodule

// File: rtl/vga_box_renderer.sv
// ---------------------------------------------------------------------------
// vga_box_renderer
// Pixel-colour stage behind the VGA timing generator. Draws a solid box
// bouncing around the 640x480 active area and re-times hSync/vSync so that
// sync and RGB leave the block on the same clock.
//
// Pipeline:
//   stage 1 : countX/countY -> box hit test -> colorS1 (registered).
//             This lines up with displayArea/hSync/vSync, which arrive one
//             cycle after the counts.
//   stage 2 : RGB = displayArea ? colorS1 : 0, hSync/vSync registered.
//   Latency : 2 cycles from countX/countY, 1 cycle from displayArea/syncs.
//
// Ports:
//   vga_clk      in   25 MHz pixel clock
//   rst          in   asynchronous active-high reset
//   countX/Y     in   pixel / line counters (10 bits)
//   displayArea  in   active-video flag (lags counts by 1)
//   hSync/vSync  in   active-low syncs (lag counts by 1)
//   move_en      in   enable box motion
//   box_color    in   12-bit box colour
//   bg_color     in   12-bit background colour
//   vga_r/g/b    out  4-bit colour channels to the DAC
//   vga_hs/vs    out  syncs aligned with RGB
//   frame_tick   out  1-cycle pulse at each vSync falling edge
//
// Build option: define VGA_BORDER_EN to draw a 4-pixel white frame around
// the active area on top of box and background.
// ---------------------------------------------------------------------------
module vga_box_renderer
    import vga_pkg::*;
#(
    parameter int BOX_W     = 32,
    parameter int BOX_H     = 32,
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 1,
    parameter int INIT_X    = 0,
    parameter int INIT_Y    = 0
) (
    input  logic         vga_clk,
    input  logic         rst,
    input  logic [9:0]   countX,
    input  logic [9:0]   countY,
    input  logic         displayArea,
    input  logic         hSync,
    input  logic         vSync,
    input  logic         move_en,
    input  logic [11:0]  box_color,
    input  logic [11:0]  bg_color,
    output logic [3:0]   vga_r,
    output logic [3:0]   vga_g,
    output logic [3:0]   vga_b,
    output logic         vga_hs,
    output logic         vga_vs,
    output logic         frame_tick
);

    coord_t boxX;
    coord_t boxY;
    rgb12_t pixColor;
    rgb12_t colorS1;
    rgb12_t rgbQ;
    logic   hsQ;
    logic   vsQ;
    logic   inBox;
    logic [10:0] cx11;
    logic [10:0] cy11;
    logic [10:0] bx11;
    logic [10:0] by11;

    // vsQ doubles as the delayed vga_vs and as the edge-detector history:
    // both are simply vSync registered, and both reset to 1 (inactive).
    assign frame_tick = vsQ & ~vSync & ~rst;

    vga_box_motion #(
        .BOX_W     (BOX_W),
        .BOX_H     (BOX_H),
        .STEP      (STEP),
        .FRAME_DIV (FRAME_DIV),
        .INIT_X    (INIT_X),
        .INIT_Y    (INIT_Y)
    ) u_motion (
        .vga_clk   (vga_clk),
        .rst       (rst),
        .frameTick (frame_tick),
        .move_en   (move_en),
        .boxX      (boxX),
        .boxY      (boxY)
    );

    // Hit test in 11 bits so boxX+BOX_W cannot wrap near the right edge.
    always_comb begin
        cx11  = {1'b0, countX};
        cy11  = {1'b0, countY};
        bx11  = {1'b0, boxX};
        by11  = {1'b0, boxY};
        inBox = (cx11 >= bx11) && (cx11 < bx11 + 11'(BOX_W)) &&
                (cy11 >= by11) && (cy11 < by11 + 11'(BOX_H));
        pixColor = inBox ? box_color : bg_color;
`ifdef VGA_BORDER_EN
        if ((countX < 10'd4) || (countX >= 10'd636) ||
            (countY < 10'd4) || (countY >= 10'd476)) begin
            pixColor = 12'hFFF;
        end
`endif
    end

    // Stage 1: colour of the pixel addressed by the counts.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            colorS1 <= '0;
        end else begin
            colorS1 <= pixColor;
        end
    end

    // Stage 2: blank outside active video, align syncs with RGB.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            rgbQ <= '0;
            hsQ  <= 1'b1;
            vsQ  <= 1'b1;
        end else begin
            rgbQ <= displayArea ? colorS1 : 12'h000;
            hsQ  <= hSync;
            vsQ  <= vSync;
        end
    end

    assign vga_r  = rgbQ[11:8];
    assign vga_g  = rgbQ[7:4];
    assign vga_b  = rgbQ[3:0];
    assign vga_hs = hsQ;
    assign vga_vs = vsQ;

endmodule

// File: tb/tb_vga_box_renderer.sv
// ---------------------------------------------------------------------------
// tb_vga_box_renderer
// Self-checking bench for vga_box_renderer with default parameters
// (32x32 box, STEP=2, FRAME_DIV=1, start at 0,0). Counts are driven
// directly (no full timing generator) so whole "frames" are only a few
// clocks: a frame is a short low pulse on vSync.
//
// Reference model: the box position after n effective updates is a
// triangle wave, pos = reflect((n*STEP) mod 2*LIMIT), where LIMIT is the
// last legal edge (608 horizontally, 448 vertically); the direction is
// negative in the falling half of the wave. Pixel colour follows directly
// from the box rectangle and the displayArea/blanking rules.
// ---------------------------------------------------------------------------
module tb_vga_box_renderer;

    logic        vga_clk = 1'b0;
    logic        rst;
    logic [9:0]  countX;
    logic [9:0]  countY;
    logic        displayArea;
    logic        hSync;
    logic        vSync;
    logic        move_en;
    logic [11:0] box_color;
    logic [11:0] bg_color;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        frame_tick;

    localparam int X_LIMIT = 640 - 32;
    localparam int Y_LIMIT = 480 - 32;

    int nChecks   = 0;
    int nFails    = 0;
    int tickCount = 0;
    int modelN    = 0;

    int          pixX[$];
    int          pixY[$];
    logic        pixDa[$];
    logic        pixHs[$];
    logic [11:0] exp_q[$];
    logic        expHs_q[$];

    vga_box_renderer dut (
        .vga_clk     (vga_clk),
        .rst         (rst),
        .countX      (countX),
        .countY      (countY),
        .displayArea (displayArea),
        .hSync       (hSync),
        .vSync       (vSync),
        .move_en     (move_en),
        .box_color   (box_color),
        .bg_color    (bg_color),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .frame_tick  (frame_tick)
    );

    // ---------------- clock / reset block ----------------
    always #20 vga_clk = ~vga_clk;

    always @(negedge vga_clk) begin
        if (frame_tick === 1'b1) tickCount++;
    end

    // ---------------- reference model ----------------
    function automatic int tri_pos(input int n, input int lim);
        int p;
        p = (n * 2) % (2 * lim);
        return (p <= lim) ? p : (2 * lim - p);
    endfunction

    function automatic logic tri_dir(input int n, input int lim);
        int p;
        p = (n * 2) % (2 * lim);
        return (p >= lim);
    endfunction

    function automatic logic [11:0] model_pix(input int cx, input int cy);
        int bx;
        int by;
        bx = tri_pos(modelN, X_LIMIT);
        by = tri_pos(modelN, Y_LIMIT);
`ifdef VGA_BORDER_EN
        if (cx < 4 || cx >= 636 || cy < 4 || cy >= 476) return 12'hFFF;
`endif
        if (cx >= bx && cx < bx + 32 && cy >= by && cy < by + 32) return box_color;
        return bg_color;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic add_pix(input int cx, input int cy);
        pixX.push_back(cx);
        pixY.push_back(cy);
        pixDa.push_back(cx < 640 && cy < 480);
        pixHs.push_back(!(cx >= 656 && cx < 752));
    endtask

    // Random pixels, half of them clustered around the model box edges.
    task automatic add_rand_pix(input int n);
        int bx;
        int by;
        int cx;
        int cy;
        bx = tri_pos(modelN, X_LIMIT);
        by = tri_pos(modelN, Y_LIMIT);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                cx = bx + $urandom_range(0, 36) - 2;
                cy = by + $urandom_range(0, 36) - 2;
                if (cx < 0) cx = 0;
                if (cy < 0) cy = 0;
            end else begin
                cx = $urandom_range(0, 799);
                cy = $urandom_range(0, 524);
            end
            add_pix(cx, cy);
        end
    endtask

    // Streams the queued pixels one per clock. displayArea/hSync for a pixel
    // are driven one clock after its counts; RGB and vga_hs are expected two
    // clocks after the counts.
    task automatic run_pixels(input string name);
        int          n;
        logic [11:0] expRgb;
        logic        expHs;
        n = pixX.size();
        exp_q.delete();
        expHs_q.delete();
        for (int i = 0; i <= n + 1; i++) begin
            @(posedge vga_clk); #1;
            if (i < n) begin
                countX = 10'(pixX[i]);
                countY = 10'(pixY[i]);
            end
            if (i >= 1 && i <= n) begin
                displayArea = pixDa[i-1];
                hSync       = pixHs[i-1];
                exp_q.push_back(pixDa[i-1] ? model_pix(pixX[i-1], pixY[i-1]) : 12'h000);
                expHs_q.push_back(pixHs[i-1]);
            end
            @(negedge vga_clk);
            if (i >= 2) begin
                expRgb = exp_q.pop_front();
                expHs  = expHs_q.pop_front();
                nChecks++;
                if ({vga_r, vga_g, vga_b} !== expRgb) begin
                    nFails++;
                    $display("FAIL %s rgb pixel(%0d,%0d): got %h expected %h",
                             name, pixX[i-2], pixY[i-2], {vga_r, vga_g, vga_b}, expRgb);
                end
                nChecks++;
                if (vga_hs !== expHs) begin
                    nFails++;
                    $display("FAIL %s vga_hs pixel(%0d,%0d): got %b expected %b",
                             name, pixX[i-2], pixY[i-2], vga_hs, expHs);
                end
            end
        end
        pixX.delete();
        pixY.delete();
        pixDa.delete();
        pixHs.delete();
        displayArea = 1'b0;
        hSync       = 1'b1;
    endtask

    // One short frame: vSync low for two clocks, high for two.
    task automatic do_frame(input logic en);
        @(posedge vga_clk); #1;
        move_en = en;
        vSync   = 1'b0;
        @(posedge vga_clk); #1;
        @(posedge vga_clk); #1;
        vSync = 1'b1;
        @(posedge vga_clk); #1;
        if (en) modelN++;
    endtask

    task automatic check_position(input string name);
        nChecks++;
        if (dut.u_motion.boxX !== 10'(tri_pos(modelN, X_LIMIT))) begin
            nFails++;
            $display("FAIL %s box_x: got %0d expected %0d", name,
                     dut.u_motion.boxX, tri_pos(modelN, X_LIMIT));
        end
        nChecks++;
        if (dut.u_motion.boxY !== 10'(tri_pos(modelN, Y_LIMIT))) begin
            nFails++;
            $display("FAIL %s box_y: got %0d expected %0d", name,
                     dut.u_motion.boxY, tri_pos(modelN, Y_LIMIT));
        end
        nChecks++;
        if (dut.u_motion.xAxis.dirNeg !== tri_dir(modelN, X_LIMIT)) begin
            nFails++;
            $display("FAIL %s dir_x: got %b expected %b", name,
                     dut.u_motion.xAxis.dirNeg, tri_dir(modelN, X_LIMIT));
        end
        nChecks++;
        if (dut.u_motion.yAxis.dirNeg !== tri_dir(modelN, Y_LIMIT)) begin
            nFails++;
            $display("FAIL %s dir_y: got %b expected %b", name,
                     dut.u_motion.yAxis.dirNeg, tri_dir(modelN, Y_LIMIT));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst         = 1'b1;
        countX      = '0;
        countY      = '0;
        displayArea = 1'b0;
        hSync       = 1'b1;
        vSync       = 1'b1;
        move_en     = 1'b1;
        box_color   = 12'hF00;
        bg_color    = 12'h00F;
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        nChecks++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_tick} !== 15'b000000000000_110) begin
            nFails++;
            $display("FAIL reset outputs: got rgb=%h hs=%b vs=%b tick=%b expected 000/1/1/0",
                     {vga_r, vga_g, vga_b}, vga_hs, vga_vs, frame_tick);
        end
        modelN = 0;
        check_position("reset");
        @(posedge vga_clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_render_basic();
        add_pix(0, 0);
        add_pix(32, 0);
        add_pix(31, 31);
        add_pix(31, 32);
        add_pix(0, 100);
        add_pix(639, 100);
        add_rand_pix(40);
        run_pixels("render_basic");
    endtask

    task automatic test_blanking();
        box_color = 12'(($urandom_range(1, 4095)));
        bg_color  = 12'(($urandom_range(1, 4095)));
        for (int k = 0; k < 30; k++) add_pix($urandom_range(640, 799), $urandom_range(0, 524));
        for (int k = 0; k < 10; k++) add_pix($urandom_range(0, 639), $urandom_range(480, 524));
        add_pix(655, 10);
        add_pix(656, 10);
        add_pix(751, 10);
        add_pix(752, 10);
        run_pixels("blanking");
        box_color = 12'hF00;
        bg_color  = 12'h00F;
    endtask

    task automatic test_motion();
        int ticks0;
        ticks0 = tickCount;
        for (int f = 0; f < 10; f++) do_frame(1'b1);
        check_position("motion_10");
        nChecks++;
        if (tickCount - ticks0 !== 10) begin
            nFails++;
            $display("FAIL motion frame_tick count: got %0d expected 10", tickCount - ticks0);
        end
        add_pix(20, 20);
        add_pix(19, 20);
        add_pix(51, 51);
        add_pix(52, 20);
        add_pix(20, 52);
        add_rand_pix(20);
        run_pixels("motion_render");
    endtask

    task automatic test_freeze();
        int ticks0;
        ticks0 = tickCount;
        for (int f = 0; f < 5; f++) do_frame(1'b0);
        check_position("freeze");
        nChecks++;
        if (tickCount - ticks0 !== 5) begin
            nFails++;
            $display("FAIL freeze frame_tick count: got %0d expected 5", tickCount - ticks0);
        end
        move_en = 1'b1;
    endtask

    // Walks the box to x=606 with randomly gated updates, then across the
    // right wall and back, checking position after every frame.
    task automatic test_bounce();
        int guard;
        guard = 0;
        while (modelN < 303 && guard < 2000) begin
            do_frame($urandom_range(0, 3) != 0);
            check_position("bounce_walk");
            guard++;
        end
        nChecks++;
        if (modelN != 303) begin
            nFails++;
            $display("FAIL bounce walk budget: reached %0d updates expected 303", modelN);
        end
        do_frame(1'b1);
        check_position("bounce_hit");
        do_frame(1'b1);
        check_position("bounce_back");
        add_rand_pix(40);
        add_pix(606, 290);
        add_pix(637, 290);
        add_pix(638, 290);
        run_pixels("bounce_render");
    endtask

    task automatic test_reset_mid_line();
        int bx;
        int by;
        bx = tri_pos(modelN, X_LIMIT);
        by = tri_pos(modelN, Y_LIMIT);
        @(posedge vga_clk); #1;
        countX = 10'(bx + 5);
        countY = 10'(by + 5);
        @(posedge vga_clk); #1;
        displayArea = 1'b1;
        hSync       = 1'b0;
        vSync       = 1'b0;
        @(posedge vga_clk); #1;
        vSync = 1'b1;
        @(negedge vga_clk);
        nChecks++;
        if ({vga_r, vga_g, vga_b, vga_hs} !== {box_color, 1'b0}) begin
            nFails++;
            $display("FAIL pre_reset pixel: got rgb=%h hs=%b expected %h/0",
                     {vga_r, vga_g, vga_b}, vga_hs, box_color);
        end
        if (modelN > 0) modelN++;
        @(posedge vga_clk); #1;
        vSync = 1'b0;
        rst   = 1'b1;
        #1;
        nChecks++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_tick} !== 15'b000000000000_110) begin
            nFails++;
            $display("FAIL mid_reset outputs: got rgb=%h hs=%b vs=%b tick=%b expected 000/1/1/0",
                     {vga_r, vga_g, vga_b}, vga_hs, vga_vs, frame_tick);
        end
        modelN = 0;
        check_position("mid_reset");
        @(posedge vga_clk); #1;
        vSync       = 1'b1;
        hSync       = 1'b1;
        displayArea = 1'b0;
        @(posedge vga_clk); #1;
        rst = 1'b0;
        add_pix(0, 0);
        add_pix(31, 0);
        add_pix(32, 0);
        add_rand_pix(20);
        run_pixels("after_reset");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_render_basic();
        test_blanking();
        test_motion();
        test_freeze();
        test_bounce();
        test_reset_mid_line();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
